// File: rtl/psc_trig_pkg.sv
// Shared types and defaults for the PSC trigger path (EVR conditioner and PSC_Trigger).
package psc_trig_pkg;

  localparam int unsigned STATE_W                = 2;
  localparam int unsigned DEFAULT_PULSE_CYCLES   = 4;
  localparam int unsigned DEFAULT_HOLDOFF_CYCLES = 50;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } trig_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/evr_trigger_conditioner_if.sv
// Control/status bundle between the EVR trigger conditioner and its host.
interface evr_trigger_conditioner_if #(
  parameter int unsigned DELAY_W = 16,
  parameter int unsigned CNT_W   = 8
);
  logic               enable;
  logic               evr_in;
  logic [DELAY_W-1:0] delay_cycles;
  logic               missed_clr;
  logic               trig_out;
  logic               busy;
  logic [CNT_W-1:0]   missed_cnt;

  modport master (
    output enable, evr_in, delay_cycles, missed_clr,
    input  trig_out, busy, missed_cnt
  );

  modport slave (
    input  enable, evr_in, delay_cycles, missed_clr,
    output trig_out, busy, missed_cnt
  );
endinterface

// File: rtl/evr_sync_edge.sv
// 2-flop synchronizer, optional glitch filter (EVR_GLITCH_FILTER_EN), registered rise pulse.
module evr_sync_edge #(
  parameter int unsigned FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

`ifdef EVR_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  localparam int unsigned RUN_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_CYCLES - 1);

  logic             sync1, sync2;
  logic             lvl_q;
  logic [RUN_W-1:0] run;
  logic             lvl_c;

  // Qualified level: synchronized high that has persisted FILTER_CYCLES samples
  assign lvl_c = FILT_EN ? (sync2 && (run == RUN_MAX)) : sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_q <= 1'b0;
      rise  <= 1'b0;
      run   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      lvl_q <= lvl_c;
      rise  <= lvl_c & ~lvl_q;
      if (!sync2)              run <= '0;
      else if (run != RUN_MAX) run <= run + RUN_W'(1);
    end
  end

endmodule

// File: rtl/evr_trigger_conditioner.sv
// EVR event line -> delayed fixed-width pulse with re-arm holdoff and missed-trigger count.
// Optional glitch filter in the input stage when EVR_GLITCH_FILTER_EN is defined.
module evr_trigger_conditioner
  import psc_trig_pkg::*;
#(
  parameter int unsigned DELAY_W        = 16,
  parameter int unsigned PULSE_CYCLES   = DEFAULT_PULSE_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned FILTER_CYCLES  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  evr_trigger_conditioner_if.slave  bus
);

  localparam int unsigned TMR_W = max3(DELAY_W, $clog2(PULSE_CYCLES + 1),
                                       $clog2(HOLDOFF_CYCLES + 1));
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  =
    TMR_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  trig_state_e      state, state_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic [CNT_W-1:0] missed_q, missed_next;
  logic             trig_q, trig_next;
  logic             busy_q, busy_next;
  logic             rise;

  evr_sync_edge #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.evr_in),
    .rise  (rise)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tmr      <= '0;
      missed_q <= '0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_next;
      tmr      <= tmr_next;
      missed_q <= missed_next;
      trig_q   <= trig_next;
      busy_q   <= busy_next;
    end
  end

  // One down-counter is reused for delay, pulse width and holdoff; each phase ends at zero
  always_comb begin
    state_next  = state;
    tmr_next    = tmr;
    missed_next = missed_q;

    case (state)
      IDLE: begin
        if (rise && bus.enable) begin
          if (bus.delay_cycles == '0) begin
            state_next = PULSE;
            tmr_next   = PULSE_LOAD;
          end else begin
            state_next = DELAY;
            tmr_next   = TMR_W'(bus.delay_cycles) - TMR_W'(1);
          end
        end
      end
      DELAY: begin
        if (tmr == '0) begin
          state_next = PULSE;
          tmr_next   = PULSE_LOAD;
        end else begin
          tmr_next = tmr - TMR_W'(1);
        end
      end
      PULSE: begin
        if (tmr == '0) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next = HOLDOFF;
            tmr_next   = HOLD_LOAD;
          end
        end else begin
          tmr_next = tmr - TMR_W'(1);
        end
      end
      HOLDOFF: begin
        if (tmr == '0) state_next = IDLE;
        else           tmr_next   = tmr - TMR_W'(1);
      end
      default: begin
        state_next = IDLE;
        tmr_next   = '0;
      end
    endcase

    if (!bus.enable) begin
      state_next = IDLE;
      tmr_next   = '0;
    end

    // Clear first so a same-cycle drop leaves a count of one
    if (bus.missed_clr) missed_next = '0;
    if (rise && bus.enable && (state != IDLE) && (missed_next != CNT_MAX))
      missed_next = missed_next + CNT_W'(1);

    trig_next = (state_next == PULSE);
    busy_next = (state_next != IDLE);
  end

  assign bus.trig_out   = trig_q;
  assign bus.busy       = busy_q;
  assign bus.missed_cnt = missed_q;

endmodule

// File: tb/tb_evr_trigger_conditioner.sv
// Directed self-checking bench for evr_trigger_conditioner (default and EVR_GLITCH_FILTER_EN builds).
module tb_evr_trigger_conditioner;

`ifdef EVR_GLITCH_FILTER_EN
  localparam int FL = 2;
`else
  localparam int FL = 0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  evr_trigger_conditioner_if #(.DELAY_W(16), .CNT_W(8)) bus ();

  evr_trigger_conditioner #(
    .DELAY_W(16), .PULSE_CYCLES(4), .HOLDOFF_CYCLES(50), .CNT_W(8), .FILTER_CYCLES(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives high windows of 'hold' samples at r0 and r1 (r1<0: none), counts trig_out pulses
  task automatic run_pulses(input int d, input int hold, input int r0, input int r1,
                            input int n, output int pulses, output int first_hi);
    logic prev;
    pulses   = 0;
    first_hi = -1;
    prev     = bus.trig_out;
    bus.delay_cycles = 16'(d);
    for (int i = 0; i <= n; i++) begin
      bus.evr_in = ((i >= r0) && (i < r0 + hold)) || ((r1 >= 0) && (i >= r1) && (i < r1 + hold));
      step();
      if (bus.trig_out && !prev) begin
        pulses++;
        if (first_hi < 0) first_hi = i;
      end
      prev = bus.trig_out;
    end
    bus.evr_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.delay_cycles = 16'd5;
    bus.missed_clr = 1'b0;
    bus.evr_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.evr_in = ~bus.evr_in;
      step();
      n_checks++;
      if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0 || bus.missed_cnt !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: trig=%b busy=%b missed=%0d, want 0/0/0",
                 i, bus.trig_out, bus.busy, bus.missed_cnt);
      end
    end
    bus.evr_in = 1'b0;
    reset = 1'b1;
    repeat (5) step();
    n_checks++;
    if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: trig=%b busy=%b, want 0/0", bus.trig_out, bus.busy);
    end
  endtask

  task automatic test_delay();
    logic exp_trig, exp_busy;
    bus.delay_cycles = 16'd10;
    for (int i = 0; i <= 70; i++) begin
      bus.evr_in = (i < 4);
      step();
      exp_trig = (i >= 13 + FL) && (i <= 16 + FL);
      exp_busy = (i >= 3 + FL) && (i <= 66 + FL);
      n_checks++;
      if (bus.trig_out !== exp_trig) begin
        n_fail++;
        $display("FAIL delay_trig k+%0d: got %b want %b", i, bus.trig_out, exp_trig);
      end
      n_checks++;
      if (bus.busy !== exp_busy) begin
        n_fail++;
        $display("FAIL delay_busy k+%0d: got %b want %b", i, bus.busy, exp_busy);
      end
    end
    bus.evr_in = 1'b0;
  endtask

  task automatic test_zero_delay();
    logic exp_trig, prev;
    int   pulses;
    bus.delay_cycles = 16'd0;
    for (int i = 0; i <= 60; i++) begin
      bus.evr_in = (i < 4);
      step();
      exp_trig = (i >= 3 + FL) && (i <= 6 + FL);
      n_checks++;
      if (bus.trig_out !== exp_trig) begin
        n_fail++;
        $display("FAIL zero_delay_trig k+%0d: got %b want %b", i, bus.trig_out, exp_trig);
      end
    end
    pulses = 0;
    prev   = bus.trig_out;
    for (int i = 0; i < 260; i++) begin
      bus.evr_in = (i < 200);
      step();
      if (bus.trig_out && !prev) pulses++;
      prev = bus.trig_out;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL held_high_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if (bus.missed_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL held_high_missed: got %0d want 0", bus.missed_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, first_hi;
    run_pulses(10, 4, 0, 20, 80, pulses, first_hi);
    n_checks++;
    if (pulses !== 1 || first_hi !== 13 + FL) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d first k+%0d want 1 first k+%0d", pulses, first_hi, 13 + FL);
    end
    n_checks++;
    if (bus.missed_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL b2b_missed: got %0d want 1", bus.missed_cnt);
    end
    // Second rise lands on the edge where holdoff expires: dropped
    run_pulses(0, 4, 0, 54, 130, pulses, first_hi);
    n_checks++;
    if (pulses !== 1 || bus.missed_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL holdoff_end_drop: pulses=%0d missed=%0d want 1/2", pulses, bus.missed_cnt);
    end
    // One cycle later the block is idle again and accepts it
    run_pulses(0, 4, 0, 55, 130, pulses, first_hi);
    n_checks++;
    if (pulses !== 2 || bus.missed_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL holdoff_rearm: pulses=%0d missed=%0d want 2/2", pulses, bus.missed_cnt);
    end
  endtask

  task automatic test_missed_saturate();
    bus.delay_cycles = 16'd2000;
    for (int i = 0; i < 10; i++) begin
      bus.evr_in = (i < 4);
      step();
    end
    for (int r = 0; r < 300; r++) begin
      for (int j = 0; j < 6; j++) begin
        bus.evr_in = (j < 4);
        step();
      end
    end
    n_checks++;
    if (bus.missed_cnt !== 8'd255 || bus.busy !== 1'b1 || bus.trig_out !== 1'b0) begin
      n_fail++;
      $display("FAIL missed_saturate: missed=%0d busy=%b trig=%b want 255/1/0",
               bus.missed_cnt, bus.busy, bus.trig_out);
    end
    for (int i = 0; i <= 10; i++) begin
      bus.evr_in = (i < 4);
      bus.missed_clr = (i == 3 + FL);
      step();
      if (i == 3 + FL) begin
        n_checks++;
        if (bus.missed_cnt !== 8'd1) begin
          n_fail++;
          $display("FAIL clr_with_drop: got %0d want 1", bus.missed_cnt);
        end
      end
    end
    bus.missed_clr = 1'b1;
    step();
    bus.missed_clr = 1'b0;
    n_checks++;
    if (bus.missed_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_alone: got %0d want 0", bus.missed_cnt);
    end
    bus.enable = 1'b0;
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.trig_out !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_idle: busy=%b trig=%b want 0/0", bus.busy, bus.trig_out);
    end
    for (int i = 0; i < 20; i++) begin
      bus.evr_in = (i < 4);
      step();
    end
    n_checks++;
    if (bus.missed_cnt !== 8'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_rise: missed=%0d busy=%b want 0/0", bus.missed_cnt, bus.busy);
    end
    bus.enable = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_enable_drop();
    bus.delay_cycles = 16'd10;
    for (int i = 0; i <= 30; i++) begin
      bus.evr_in = (i < 4);
      if (i == 7) bus.enable = 1'b0;
      step();
      if (i == 7) begin
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL enable_drop_busy: got %b want 0", bus.busy);
        end
      end
      if (i >= 7) begin
        n_checks++;
        if (bus.trig_out !== 1'b0) begin
          n_fail++;
          $display("FAIL enable_drop_trig k+%0d: got %b want 0", i, bus.trig_out);
        end
      end
    end
    bus.enable = 1'b1;
    repeat (3) step();
    bus.delay_cycles = 16'd0;
    for (int i = 0; i <= 4 + FL; i++) begin
      bus.evr_in = (i < 4);
      step();
    end
    n_checks++;
    if (bus.trig_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: got %b want 1", bus.trig_out);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0 || bus.missed_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: trig=%b busy=%b missed=%0d want 0/0/0",
               bus.trig_out, bus.busy, bus.missed_cnt);
    end
    bus.evr_in = 1'b0;
    reset = 1'b1;
    repeat (5) step();
  endtask

`ifdef EVR_GLITCH_FILTER_EN
  task automatic test_filter();
    int pulses, first_hi;
    logic exp_trig;
    run_pulses(10, 2, 0, -1, 40, pulses, first_hi);
    n_checks++;
    if (pulses !== 0 || bus.busy !== 1'b0 || bus.missed_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch_reject: pulses=%0d busy=%b missed=%0d want 0/0/0",
               pulses, bus.busy, bus.missed_cnt);
    end
    bus.delay_cycles = 16'd10;
    for (int i = 0; i <= 75; i++) begin
      bus.evr_in = (i < 3);
      step();
      exp_trig = (i >= 15) && (i <= 18);
      n_checks++;
      if (bus.trig_out !== exp_trig) begin
        n_fail++;
        $display("FAIL filter_trig k+%0d: got %b want %b", i, bus.trig_out, exp_trig);
      end
    end
    bus.evr_in = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_delay();
    test_zero_delay();
    test_back_to_back();
    test_missed_saturate();
    test_enable_drop();
`ifdef EVR_GLITCH_FILTER_EN
    test_filter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
